// File: rtl/rx_fifo_pkg.sv
// Shared sizing, entry payload type and helpers for the receive byte-to-word FIFO.
package rx_fifo_pkg;

  localparam int unsigned DEPTH          = 8;
  localparam int unsigned PTR_W          = 3;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned SIDE_W         = 2;
  localparam int unsigned COUNT_W        = 3;
  localparam int unsigned OCC_W          = 4;

  // One committed word; cnt encodes the number of valid bytes, with 0 meaning all four.
  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [SIDE_W-1:0] cnt;
  } rx_entry_t;

  function automatic logic [COUNT_W-1:0] cnt_to_bytes(input logic [SIDE_W-1:0] cnt);
    return (cnt == '0) ? COUNT_W'(BYTES_PER_WORD) : COUNT_W'(cnt);
  endfunction

endpackage

// File: rtl/rx_comb_output.sv
// Full/empty decode from the head/tail pointers and their wrap toggles.
module rx_comb_output
  import rx_fifo_pkg::*;
(
  input  logic [PTR_W-1:0] tail_ptr,
  input  logic             tail_tog,
  input  logic [PTR_W-1:0] head_ptr,
  input  logic             head_tog,
  output logic             full,
  output logic             empty
);

  logic ptr_eq;

  assign ptr_eq = (tail_ptr == head_ptr);
  assign full   = ptr_eq && (tail_tog != head_tog);
  assign empty  = ptr_eq && (tail_tog == head_tog);

endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO: packs bytes little-endian into 32-bit words and queues 8 words.
// Optional registered occupancy port is enabled by defining RX_FIFO_OCCUPANCY_EN.
module rx_fifo
  import rx_fifo_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               w_enable,
  input  logic [BYTE_W-1:0]  w_data,
  input  logic               w_flush,
  input  logic               r_enable,
  output logic [WORD_W-1:0]  r_data,
  output logic [COUNT_W-1:0] r_count,
  output logic               full,
  output logic               empty,
  output logic               overrun
`ifdef RX_FIFO_OCCUPANCY_EN
  ,
  output logic [OCC_W-1:0]   occupancy
`endif
);

  rx_entry_t         mem [DEPTH];
  rx_entry_t         head_entry;
  logic [PTR_W-1:0]  tail_ptr;
  logic [PTR_W-1:0]  head_ptr;
  logic              tail_tog;
  logic              head_tog;
  logic [SIDE_W-1:0] tail_side;
  logic [WORD_W-1:0] staging;

  logic [WORD_W-1:0] staged_word;
  logic [SIDE_W-1:0] commit_cnt;
  logic              commit_req;
  logic              do_read;
  logic              commit_ok;
  logic              do_commit;
  logic              drop;

  rx_comb_output u_comb_output (
    .tail_ptr (tail_ptr),
    .tail_tog (tail_tog),
    .head_ptr (head_ptr),
    .head_tog (head_tog),
    .full     (full),
    .empty    (empty)
  );

  // Staging word with any same-cycle byte merged into its lane.
  always_comb begin
    staged_word = staging;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (w_enable && (tail_side == SIDE_W'(i))) begin
        staged_word[i*BYTE_W +: BYTE_W] = w_data;
      end
    end
  end

  // Commit on the fourth byte or on a flush with something staged; a full FIFO
  // still accepts when a same-cycle read frees the head slot.
  always_comb begin
    commit_cnt = SIDE_W'(tail_side + SIDE_W'(w_enable));
    commit_req = (w_enable && (tail_side == SIDE_W'(BYTES_PER_WORD - 1))) ||
                 (w_flush && ((tail_side != '0) || w_enable));
    do_read    = r_enable && !empty;
    commit_ok  = !full || do_read;
    do_commit  = commit_req && commit_ok;
    drop       = commit_req && !commit_ok;
  end

  // Pointers: the toggle is the carry out of the 3-bit index.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tail_ptr <= '0;
      tail_tog <= 1'b0;
      head_ptr <= '0;
      head_tog <= 1'b0;
    end else begin
      if (do_commit) begin
        {tail_tog, tail_ptr} <= (PTR_W + 1)'({tail_tog, tail_ptr} + 1'b1);
      end
      if (do_read) begin
        {head_tog, head_ptr} <= (PTR_W + 1)'({head_tog, head_ptr} + 1'b1);
      end
    end
  end

  // Staging register; emptied on every commit attempt, accepted or dropped.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tail_side <= '0;
      staging   <= '0;
    end else if (commit_req) begin
      tail_side <= '0;
      staging   <= '0;
    end else if (w_enable) begin
      tail_side <= SIDE_W'(tail_side + 1'b1);
      staging   <= staged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

  // Entry storage carries no reset; pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_commit && !rst && !clear) begin
      mem[tail_ptr] <= '{word: staged_word, cnt: commit_cnt};
    end
  end

  assign head_entry = mem[head_ptr];
  assign r_data     = empty ? '0 : head_entry.word;
  assign r_count    = empty ? '0 : cnt_to_bytes(head_entry.cnt);

`ifdef RX_FIFO_OCCUPANCY_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      occupancy <= '0;
    end else begin
      case ({do_commit, do_read})
        2'b10:   occupancy <= OCC_W'(occupancy + 1'b1);
        2'b01:   occupancy <= OCC_W'(occupancy - 1'b1);
        default: occupancy <= occupancy;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo; RX_FIFO_OCCUPANCY_EN also checks occupancy.
module tb_rx_fifo;
  logic        clk = 1'b0;
  logic        rst, clear, w_enable, w_flush, r_enable;
  logic [7:0]  w_data;
  logic [31:0] r_data;
  logic [2:0]  r_count;
  logic        full, empty, overrun;
`ifdef RX_FIFO_OCCUPANCY_EN
  logic [3:0]  occupancy;
`endif
  int tests = 0;
  int fails = 0;

  rx_fifo dut (
    .clk(clk), .rst(rst), .clear(clear), .w_enable(w_enable), .w_data(w_data),
    .w_flush(w_flush), .r_enable(r_enable), .r_data(r_data), .r_count(r_count),
    .full(full), .empty(empty), .overrun(overrun)
`ifdef RX_FIFO_OCCUPANCY_EN
    , .occupancy(occupancy)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    w_enable = 0; w_flush = 0; r_enable = 0; clear = 0; rst = 0; w_data = 8'h00;
  endtask

  task automatic wr(input logic [7:0] b, input logic fl, input logic rd);
    w_enable = 1; w_data = b; w_flush = fl; r_enable = rd;
    tick();
    idle();
  endtask

  task automatic rd_word;
    r_enable = 1;
    tick();
    idle();
  endtask

  task automatic do_clear;
    clear = 1;
    tick();
    idle();
  endtask

  function automatic logic [31:0] seq_word(input int base);
    return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
  endfunction

  task automatic test_reset;
    idle(); rst = 1; tick(); tick(); idle();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    tests++; if (r_data !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", r_data); end
    tests++; if (r_count !== 3'd0) begin fails++; $display("FAIL reset_rcount got %0d exp 0", r_count); end
`ifdef RX_FIFO_OCCUPANCY_EN
    tests++; if (occupancy !== 4'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
`endif
  endtask

  task automatic test_word;
    wr(8'h11, 0, 0); wr(8'h22, 0, 0); wr(8'h33, 0, 0);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL word_partial_empty got %b exp 1", empty); end
    wr(8'h44, 0, 0);
    tests++; if (r_data !== 32'h44332211) begin fails++; $display("FAIL word_rdata got %h exp 44332211", r_data); end
    tests++; if (r_count !== 3'd4) begin fails++; $display("FAIL word_rcount got %0d exp 4", r_count); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL word_empty got %b exp 0", empty); end
`ifdef RX_FIFO_OCCUPANCY_EN
    tests++; if (occupancy !== 4'd1) begin fails++; $display("FAIL word_occ got %0d exp 1", occupancy); end
`endif
    rd_word();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL word_drain_empty got %b exp 1", empty); end
  endtask

  task automatic test_flush;
    w_flush = 1; tick(); idle();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL flush_nothing_empty got %b exp 1", empty); end
    wr(8'hAA, 0, 0); wr(8'hBB, 0, 0);
    w_flush = 1; tick(); idle();
    tests++; if (r_data !== 32'h0000BBAA) begin fails++; $display("FAIL flush2_rdata got %h exp 0000bbaa", r_data); end
    tests++; if (r_count !== 3'd2) begin fails++; $display("FAIL flush2_rcount got %0d exp 2", r_count); end
    rd_word();
    wr(8'hCC, 1, 0);
    tests++; if (r_data !== 32'h000000CC) begin fails++; $display("FAIL flush1_rdata got %h exp 000000cc", r_data); end
    tests++; if (r_count !== 3'd1) begin fails++; $display("FAIL flush1_rcount got %0d exp 1", r_count); end
    rd_word();
    wr(8'h01, 0, 0); wr(8'h02, 0, 0); wr(8'h03, 1, 0);
    tests++; if (r_count !== 3'd3) begin fails++; $display("FAIL flush3_rcount got %0d exp 3", r_count); end
    tests++; if (r_data !== 32'h00030201) begin fails++; $display("FAIL flush3_rdata got %h exp 00030201", r_data); end
    rd_word();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL flush_drain_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_overrun;
    do_clear();
    for (int i = 0; i < 32; i++) wr(8'(i), 0, 0);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovr_full got %b exp 1", full); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_pre got %b exp 0", overrun); end
    for (int i = 32; i < 36; i++) wr(8'(i), 0, 0);
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set got %b exp 1", overrun); end
    tests++; if (r_data !== 32'h03020100) begin fails++; $display("FAIL ovr_head got %h exp 03020100", r_data); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovr_full_after got %b exp 1", full); end
    rd_word();
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
    tests++; if (r_data !== 32'h07060504) begin fails++; $display("FAIL ovr_second got %h exp 07060504", r_data); end
    do_clear();
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovr_clear_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_read_commit;
    do_clear();
    for (int i = 0; i < 32; i++) wr(8'(i), 0, 0);
    wr(8'hE0, 0, 0); wr(8'hE1, 0, 0); wr(8'hE2, 0, 0);
    wr(8'hE3, 0, 1);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL frc_full got %b exp 1", full); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL frc_overrun got %b exp 0", overrun); end
    tests++; if (r_data !== 32'h07060504) begin fails++; $display("FAIL frc_head got %h exp 07060504", r_data); end
`ifdef RX_FIFO_OCCUPANCY_EN
    tests++; if (occupancy !== 4'd8) begin fails++; $display("FAIL frc_occ got %0d exp 8", occupancy); end
`endif
    for (int k = 1; k < 8; k++) begin
      tests++;
      if (r_data !== seq_word(4 * k)) begin
        fails++; $display("FAIL frc_drain%0d got %h exp %h", k, r_data, seq_word(4 * k));
      end
      rd_word();
    end
    tests++; if (r_data !== 32'hE3E2E1E0) begin fails++; $display("FAIL frc_last got %h exp e3e2e1e0", r_data); end
    rd_word();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL frc_empty got %b exp 1", empty); end
  endtask

  task automatic test_wrap;
    do_clear();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) wr(8'(64 * r + 100 + i), 0, 0);
      tests++; if (full !== 1'b1) begin fails++; $display("FAIL wrap%0d_full got %b exp 1", r, full); end
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (r_data !== seq_word(64 * r + 100 + 4 * k)) begin
          fails++; $display("FAIL wrap%0d_word%0d got %h exp %h", r, k, r_data, seq_word(64 * r + 100 + 4 * k));
        end
        rd_word();
      end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap%0d_empty got %b exp 1", r, empty); end
    end
  endtask

  task automatic test_clear;
    wr(8'h55, 0, 0); wr(8'h66, 0, 0);
    clear = 1; w_enable = 1; w_data = 8'h77; w_flush = 1; tick(); idle();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL clr_empty got %b exp 1", empty); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL clr_overrun got %b exp 0", overrun); end
    r_enable = 1; tick(); idle();
    wr(8'h01, 0, 0); wr(8'h02, 0, 0); wr(8'h03, 0, 0); wr(8'h04, 0, 0);
    tests++; if (r_data !== 32'h04030201) begin fails++; $display("FAIL clr_realign got %h exp 04030201", r_data); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL clr_notempty got %b exp 0", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL clr_notfull got %b exp 0", full); end
  endtask

  task automatic test_back_to_back;
    wr(8'hA0, 0, 0); wr(8'hA1, 0, 0); wr(8'hA2, 0, 0);
    wr(8'hA3, 0, 1);
    tests++; if (r_data !== 32'hA3A2A1A0) begin fails++; $display("FAIL b2b_head got %h exp a3a2a1a0", r_data); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b exp 0", empty); end
`ifdef RX_FIFO_OCCUPANCY_EN
    tests++; if (occupancy !== 4'd1) begin fails++; $display("FAIL b2b_occ got %0d exp 1", occupancy); end
`endif
    rd_word();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_drain got %b exp 1", empty); end
  endtask

  initial begin
    idle();
    test_reset();
    test_word();
    test_flush();
    test_full_overrun();
    test_full_read_commit();
    test_wrap();
    test_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 SHALL have these ports, in this order:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- clear  in  1  synchronous flush of all FIFO state.
- w_enable  in  1  byte-write strobe from receive decoder.
- w_data  in  8  byte to write.
- w_flush  in  1  end of packet; commit partial word.
- r_enable  in  1  word-read strobe from bus side.
- r_data  out  32  head word.
- r_count  out  3  valid bytes in head word, 1..4; 0 when empty.
- full  out  1  all 8 word entries occupied.
- empty  out  1  no committed words.
- overrun  out  1  sticky; a byte or commit was dropped.
- occupancy  out  4  committed words, 0..8; present only under RX_FIFO_OCCUPANCY_EN.
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL store 8 entries, each a 32-bit word plus a 2-bit byte count; count encoding 0 means 4 bytes.
REQ-004 SHALL pack written bytes little-endian into a staging word: byte index tail_side (0..3) goes to bits [8*tail_side+7 : 8*tail_side].
REQ-005 On w_enable, SHALL write w_data at tail_side and increment tail_side mod 4.
REQ-006 When w_enable writes at tail_side=3, SHALL commit the staging word (count 4) at tail_ptr in the same cycle, advance tail_ptr and clear tail_side.
REQ-007 On w_flush with staging non-empty (tail_side!=0, or w_enable the same cycle), SHALL commit the staging word including any same-cycle byte, with count equal to the bytes held, and clear tail_side; w_flush with nothing staged SHALL do nothing.
REQ-008 tail_ptr and head_ptr SHALL be 3 bits, each with a toggle bit that inverts on wrap 7->0.
REQ-009 SHALL set full when ptrs are equal and toggles differ; empty when ptrs are equal and toggles are equal; both combinational from registered state.
REQ-010 SHALL allow a commit when !full, or when full and r_enable is high the same cycle (read frees the slot first).
REQ-011 A commit refused by REQ-010 SHALL drop the staging word, clear tail_side and set overrun.
REQ-012 r_data/r_count SHALL show the head entry combinationally with zero latency; r_data=0 and r_count=0 when empty.
REQ-013 r_enable with !empty SHALL advance head_ptr at the next edge; r_enable while empty SHALL be ignored.
REQ-014 A simultaneous read and commit SHALL leave occupancy unchanged.
REQ-015 clear SHALL act exactly as reset on all state, and SHALL take priority over same-cycle writes and reads.
REQ-016 overrun SHALL remain set until clear or rst.

Reset
REQ-017 On rst: pointers, toggles and tail_side SHALL be 0; empty=1; full=0; overrun=0; r_data=0; r_count=0; occupancy=0.
REQ-018 Reset mid-packet SHALL discard staged bytes; the entry array is not required to be cleared.

Configuration
REQ-019 With RX_FIFO_OCCUPANCY_EN defined, SHALL provide a registered occupancy output updated by +1 on commit, -1 on read, and unchanged on both; without the macro, the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-020 Package rx_fifo_pkg SHALL hold DEPTH=8, PTR_W=3, WORD_W=32, and the typedef rx_entry_t {word, cnt}.
REQ-021 Full/empty decode SHALL be a sub-module rx_comb_output (ptrs and toggles in, full/empty out).

Verification
REQ-022 Bytes 0x11,0x22,0x33,0x44 written -> r_data=0x44332211, r_count=4, empty=0 on the next cycle.
REQ-023 Bytes 0xAA,0xBB then w_flush -> r_data=0x0000BBAA, r_count=2; a w_flush with nothing staged leaves empty=1.
REQ-024 32 bytes written with no reads -> full=1; a 33rd through 36th byte -> overrun=1 and the head word is unchanged.
REQ-025 Full FIFO plus a 4th staged byte with r_enable the same cycle -> commit accepted, full stays 1, overrun=0.
REQ-026 8 words filled and drained twice (pointer wrap) -> data returned in order; clear mid-packet -> empty=1, tail_side=0, overrun=0.
